cmac_tx_pkt_buffer: RTL
=======================

# cmac_tx_pkt_buffer

Store-and-forward packet buffer placed directly upstream of the AXI4-Stream to LBUS TX converter on the CMAC transmit path. The converter requires every packet to arrive with no valid gaps once it has started. This block therefore releases a packet downstream only after its last beat has been written. A packet is never starved mid-flight. Packets longer than the buffer are discarded and counted, so an oversized packet cannot deadlock the path.

## Interface
Parameters:
- DEPTH, 128: buffer depth in 512-bit beats; power of two, at least 4.
- DATA_WIDTH, 512: tdata width. Fixed to match the CMAC LBUS converter.

Ports:
- CLK  in  1  user clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- S_AXIS  axi4_stream.slave  input packet stream.
  - tdata: 512 bits. Byte 0 is tdata[7:0].
  - tstrb: 64 bits, contiguous from bit 0.
  - tlast: 1 bit, marks the final beat of a packet.
  - tvalid/tready: handshake.
- M_AXIS  axi4_stream.master  output stream. Same fields as S_AXIS; feeds the LBUS TX converter.
- OCCUPANCY  out  $clog2(DEPTH)+1  number of beats stored, counting both committed and in-progress packets.
- PKT_COUNT  out  $clog2(DEPTH)+1  number of complete packets stored and not yet fully read.
- DROP_CNT  out  32  number of oversized packets discarded; saturates at 32'hFFFF_FFFF.
- DROP_PULSE  out  1  one-cycle pulse when a drop decision is taken.

## Operation
- Storage: circular RAM with four pointers.
  - rd_ptr: next beat to read.
  - wr_start: first beat of the current incoming packet.
  - wr_cur: next write slot.
  - cur_len: beats of the current packet written so far.
  - All pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full: wr_cur − rd_ptr == DEPTH.
  - Empty for reading: rd_ptr == wr_start.
- Write FSM, state ACCEPT:
  - Each accepted beat is written at wr_cur; then wr_cur and cur_len increment.
  - On an accepted tlast beat: wr_start ← wr_cur+1, cur_len ← 0, PKT_COUNT increments.
- Write FSM, transition to DISCARD:
  - Trigger: a beat is accepted while cur_len == DEPTH and that beat is not the packet's own tlast-terminated DEPTH-th beat.
  - Action: wr_cur ← wr_start, cur_len ← 0, DROP_CNT increments, DROP_PULSE fires.
  - If the triggering beat carries tlast, the FSM stays in ACCEPT. Otherwise it moves to DISCARD.
- Write FSM, state DISCARD:
  - Beats are accepted and thrown away until tlast inclusive, then the FSM returns to ACCEPT.
- S_AXIS.tready = !RST && (state==DISCARD || !full || cur_len==DEPTH).
- Read side:
  - Only committed beats are read, i.e. rd_ptr ≠ wr_start.
  - RAM read has 1-cycle latency. A 2-entry output skid register drives M_AXIS so sustained throughput is 1 beat/cycle.
  - PKT_COUNT decrements when a tlast beat leaves the RAM read port.
  - Once M_AXIS.tvalid rises for a first beat, it stays high every cycle until that packet's tlast handshake. The only exception is M_AXIS.tready back-pressure, which holds the data.
- Simultaneous commit and read-out of tlast in the same cycle: PKT_COUNT is unchanged.
- tdata, tstrb and tlast pass through unmodified. No reordering and no padding.

## Timing
- Reset values:
  - All outputs low.
  - DROP_CNT = 0, OCCUPANCY = 0, PKT_COUNT = 0.
  - All pointers 0, FSM in ACCEPT, skid register empty.
  - S_AXIS.tready = 0 while RST is high.
- After RST deasserts, tready rises combinationally, provided no other condition holds it low.
- Latency: if the tlast beat of a packet is accepted in cycle N, with the buffer otherwise empty and M_AXIS.tready high, the first beat appears on M_AXIS in cycle N+3.
- Throughput: back-to-back packets stream with no idle cycles between them.
- Reset mid-packet: all stored and partial data is lost. No partial packet is emitted after reset.

## Structure
- Put DATA_WIDTH, the strobe width (DATA_WIDTH/8) and the FSM state enum (ACCEPT, DISCARD) in the shared cmac package.
- Use one sub-module, cmac_sdp_ram: simple dual-port synchronous RAM, DEPTH×(DATA_WIDTH+64+1) bits, 1-cycle read latency.
- The top level holds the pointers, the FSM, the counters and the skid register.

## Test plan
- Single 1-beat packet, tstrb = 64'h0000_0000_0000_FFFF, tlast=1, accepted at cycle 10 → M_AXIS shows the same beat at cycle 13; PKT_COUNT goes 0→1→0.
- 4-beat packet with 5 idle cycles between input beats → M_AXIS emits all 4 beats on consecutive cycles, only after input tlast.
- Oversized packet with DEPTH=8, 10 beats → DROP_CNT = 1, DROP_PULSE once, M_AXIS never asserts, OCCUPANCY returns to 0, and a following 2-beat packet is forwarded intact.
- Exactly DEPTH-beat packet → forwarded, no drop, and tready stays high throughout.
- M_AXIS.tready held low while 3 packets are written until the buffer is full → S_AXIS.tready = 0; releasing M_AXIS.tready drains all packets in order with data matching.
- RST asserted mid-packet with 2 complete packets stored → all outputs go to reset values immediately; after release, no stale beats are emitted.

Source files
------------

// File: rtl/cmac_tx_pkt_buffer_pkg.sv
// Shared types and constants for the CMAC TX store-and-forward packet buffer.
// Contents: beat width constants, write-side FSM state enum, packed beat payload.
package cmac_tx_pkt_buffer_pkg;

  localparam int unsigned DATA_WIDTH = 512;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BEAT_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic                  last;
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/cmac_sdp_ram.sv
// Simple dual-port synchronous RAM, one write port and one read port, 1-cycle
// read latency.
// Ports: CLK; we/waddr/wdata write port; re/raddr read request; rdata read
// data valid the cycle after re.
module cmac_sdp_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = cmac_tx_pkt_buffer_pkg::BEAT_WIDTH
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cmac_tx_pkt_buffer.sv
// Store-and-forward TX packet buffer ahead of the AXI4-Stream to LBUS converter.
// A packet is released only once its tlast beat is stored, so the output never
// gaps mid-packet; packets longer than DEPTH beats are dropped and counted.
// Ports: CLK/RST (async active-high); S_AXIS_* input stream; M_AXIS_* output
// stream; OCCUPANCY beats held in RAM; PKT_COUNT complete packets not yet read
// from RAM; DROP_CNT saturating drop counter; DROP_PULSE one cycle per drop.
module cmac_tx_pkt_buffer #(
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned DATA_WIDTH = cmac_tx_pkt_buffer_pkg::DATA_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_tstrb,
  input  logic                    S_AXIS_tlast,
  input  logic                    S_AXIS_tvalid,
  output logic                    S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tstrb,
  output logic                    M_AXIS_tlast,
  output logic                    M_AXIS_tvalid,
  input  logic                    M_AXIS_tready,
  output logic [$clog2(DEPTH):0]  OCCUPANCY,
  output logic [$clog2(DEPTH):0]  PKT_COUNT,
  output logic [31:0]             DROP_CNT,
  output logic                    DROP_PULSE
);

  import cmac_tx_pkt_buffer_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  wr_state_e     state;
  logic [PW-1:0] rd_ptr, wr_start, wr_cur, cur_len;
  logic          rd_pending;
  logic [1:0]    skid_cnt, skid_cnt_nxt;
  beat_t         skid0, skid1, ram_q, s_beat;

  logic          full, at_limit, s_fire, wr_en, drop, commit;
  logic          pop, ren, rd_tlast;
  logic [2:0]    slots;

  // Handshake decode, RAM read scheduling and skid occupancy
  always_comb begin
    full          = 1'b0;
    at_limit      = 1'b0;
    S_AXIS_tready = 1'b0;
    s_fire        = 1'b0;
    wr_en         = 1'b0;
    drop          = 1'b0;
    commit        = 1'b0;
    pop           = 1'b0;
    slots         = 3'd0;
    ren           = 1'b0;
    rd_tlast      = 1'b0;
    skid_cnt_nxt  = skid_cnt;
    s_beat        = '0;

    full          = (wr_cur - rd_ptr) == DEPTH_P;
    at_limit      = (cur_len == DEPTH_P);
    // At the limit the beat is accepted but never written: it triggers the drop.
    S_AXIS_tready = !RST && ((state == DISCARD) || !full || at_limit);
    s_fire        = S_AXIS_tvalid && S_AXIS_tready;
    drop          = s_fire && (state == ACCEPT) && at_limit;
    wr_en         = s_fire && (state == ACCEPT) && !at_limit;
    commit        = wr_en && S_AXIS_tlast;

    pop           = M_AXIS_tvalid && M_AXIS_tready;
    // Issue a read only if the skid has a slot when the data lands next cycle.
    slots         = 3'(skid_cnt) + 3'(rd_pending) - 3'(pop);
    ren           = (rd_ptr != wr_start) && (slots <= 3'd1);
    rd_tlast      = rd_pending && ram_q.last;
    skid_cnt_nxt  = skid_cnt + 2'(rd_pending) - 2'(pop);

    s_beat.last   = S_AXIS_tlast;
    s_beat.strb   = S_AXIS_tstrb;
    s_beat.data   = S_AXIS_tdata;
  end

  cmac_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_WIDTH)
  ) u_ram (
    .CLK   (CLK),
    .we    (wr_en),
    .waddr (wr_cur[AW-1:0]),
    .wdata (s_beat),
    .re    (ren),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  // Write FSM, pointers, counters and output skid register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= ACCEPT;
      rd_ptr        <= '0;
      wr_start      <= '0;
      wr_cur        <= '0;
      cur_len       <= '0;
      rd_pending    <= 1'b0;
      skid_cnt      <= 2'd0;
      skid0         <= '0;
      skid1         <= '0;
      M_AXIS_tvalid <= 1'b0;
      OCCUPANCY     <= '0;
      PKT_COUNT     <= '0;
      DROP_CNT      <= '0;
      DROP_PULSE    <= 1'b0;
    end else begin
      DROP_PULSE <= drop;

      if (state == ACCEPT) begin
        if (drop) begin
          wr_cur  <= wr_start;
          cur_len <= '0;
          if (!S_AXIS_tlast) state <= DISCARD;
        end else if (wr_en) begin
          wr_cur <= wr_cur + PW'(1);
          if (S_AXIS_tlast) begin
            wr_start <= wr_cur + PW'(1);
            cur_len  <= '0;
          end else begin
            cur_len <= cur_len + PW'(1);
          end
        end
      end else if (s_fire && S_AXIS_tlast) begin
        state <= ACCEPT;
      end

      if (drop && (DROP_CNT != 32'hFFFF_FFFF)) DROP_CNT <= DROP_CNT + 32'd1;

      if (ren) rd_ptr <= rd_ptr + PW'(1);
      rd_pending <= ren;

      // Tracks wr_cur - rd_ptr; a drop rewinds wr_cur by cur_len.
      OCCUPANCY <= OCCUPANCY + PW'(wr_en) - PW'(ren) - (drop ? cur_len : '0);

      if (commit && !rd_tlast)      PKT_COUNT <= PKT_COUNT + PW'(1);
      else if (!commit && rd_tlast) PKT_COUNT <= PKT_COUNT - PW'(1);

      // Two-entry skid: skid0 is always the head presented on M_AXIS.
      if (pop) begin
        if (skid_cnt == 2'd2) begin
          skid0 <= skid1;
          if (rd_pending) skid1 <= ram_q;
        end else if (rd_pending) begin
          skid0 <= ram_q;
        end
      end else if (rd_pending) begin
        if (skid_cnt == 2'd0) skid0 <= ram_q;
        else                  skid1 <= ram_q;
      end
      skid_cnt      <= skid_cnt_nxt;
      M_AXIS_tvalid <= (skid_cnt_nxt != 2'd0);
    end
  end

  assign M_AXIS_tdata = skid0.data;
  assign M_AXIS_tstrb = skid0.strb;
  assign M_AXIS_tlast = skid0.last;

endmodule
